bcd_converter_seq: RTL

//   Multi-cycle, parametrised binary-to-BCD converter (shift-and-add-3, one bit per clock)

---
 rtl/bcd_converter_seq.sv | 138 +++++++++++++
 1 files changed

// File: rtl/bcd_converter_seq.sv
// Multi-cycle binary-to-BCD converter (shift-and-add-3, one input bit per clock)
// with valid/ready handshakes on both sides and optional sign+magnitude input.
module bcd_converter_seq #(
  parameter int unsigned IN_WIDTH = 10,
  parameter int unsigned DIGITS   = 4,
  parameter bit          SIGNED   = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_WIDTH-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  negative,
  output logic                  overflow
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = (IN_WIDTH > 2) ? $clog2(IN_WIDTH) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CONVERT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]          state_q,     state_d;
  logic [IN_WIDTH-1:0] mag_q,       mag_d;
  logic [BCD_W-1:0]    acc_q,       acc_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic [BCD_W-1:0]    bcd_q,       bcd_d;
  logic                negative_q,  negative_d;
  logic                overflow_q,  overflow_d;
  logic                out_valid_q, out_valid_d;

  logic                accept;
  logic                in_neg;
  logic [IN_WIDTH-1:0] in_mag;
  logic [BCD_W-1:0]    acc_adj;
  logic [BCD_W-1:0]    acc_next;
  logic [IN_WIDTH-1:0] mag_next;
  logic                carry_out;

  assign in_ready = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign accept   = in_valid & in_ready;

  // Two's complement magnitude; the most negative input maps to 2**(IN_WIDTH-1).
  assign in_neg = SIGNED && in_data[IN_WIDTH-1];
  assign in_mag = in_neg ? ~(in_data - IN_WIDTH'(1)) : in_data;

  // One double-dabble step: add 3 to every digit >= 5, then shift {acc, mag} left.
  always_comb begin
    acc_adj = acc_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
    carry_out = acc_adj[BCD_W-1];
    acc_next  = {acc_adj[BCD_W-2:0], mag_q[IN_WIDTH-1]};
    mag_next  = {mag_q[IN_WIDTH-2:0], 1'b0};
  end

  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    bcd_d       = bcd_q;
    negative_d  = negative_q;
    overflow_d  = overflow_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: begin
      end
      S_CONVERT: begin
        acc_d      = acc_next;
        mag_d      = mag_next;
        overflow_d = overflow_q | carry_out;
        cnt_d      = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d     = S_DONE;
          bcd_d       = acc_next;
          out_valid_d = 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    // Accept is only possible from IDLE or from DONE while the result is consumed.
    if (accept) begin
      state_d    = S_CONVERT;
      mag_d      = in_mag;
      acc_d      = '0;
      cnt_d      = CNT_W'(IN_WIDTH - 1);
      negative_d = in_neg;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mag_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      bcd_q       <= '0;
      negative_q  <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      bcd_q       <= bcd_d;
      negative_q  <= negative_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign bcd       = bcd_q;
  assign negative  = negative_q;
  assign overflow  = overflow_q;

endmodule
